// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the AXI-Stream switch (demux_unit and mux_unit).
package axis_switch_pkg;

  // Demux packet-routing state: waiting for a first beat, locked to an output,
  // or swallowing a packet whose destination does not exist.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } demux_state_t;

  // Width needed to index n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry pipeline register with valid/ready, carrying data, last and a
// sideband select field. Accepts a new beat in the same cycle the held beat
// drains, so a continuously ready sink sees one beat per cycle.
module axis_reg_slice #(
  parameter int DATA_W = 64,
  parameter int SEL_W  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic [SEL_W-1:0]  in_sel_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic [SEL_W-1:0]  out_sel_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  // Next-state: a loaded beat overwrites the register (even while draining);
  // otherwise a drain empties it and a stall keeps everything frozen.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = in_data_i;
      last_d  = in_last_i;
      sel_d   = in_sel_i;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Register update; reset discards any pending beat and zeroes the payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign out_sel_o   = sel_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/demux_unit.sv
// Per-source-port AXI-Stream demultiplexer: routes each whole packet to the
// output named by its first beat's dest, tags beats with this port's index,
// and discards packets addressed to a non-existent output.
module demux_unit
  import axis_switch_pkg::*;
#(
  parameter int S_DATA_COUNT = 10,
  parameter int M_DATA_COUNT = 10,
  parameter int T_DATA_WIDTH = 64,
  parameter int NUM_CHANNEL  = 0,
  parameter int T_ID_WIDTH   = clog2_min1(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = clog2_min1(M_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_DEST_WIDTH-1:0] s_dest_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [M_DATA_COUNT],
  output logic [T_ID_WIDTH-1:0]   m_id_o   [M_DATA_COUNT],
  output logic [M_DATA_COUNT-1:0] m_last_o,
  output logic [M_DATA_COUNT-1:0] m_valid_o,
  input  logic [M_DATA_COUNT-1:0] m_ready_i,
  output logic                    drop_o
);

  localparam logic [T_DEST_WIDTH:0] MCountExt = (T_DEST_WIDTH + 1)'(M_DATA_COUNT);
  localparam logic [T_ID_WIDTH-1:0] ChanId    = T_ID_WIDTH'(NUM_CHANNEL);

  demux_state_t            state_q;
  logic [T_DEST_WIDTH-1:0] sel_q;
  logic                    drop_q;

  logic                    dest_ok;
  logic                    fire;
  logic                    fwd_valid;
  logic [T_DEST_WIDTH-1:0] fwd_sel;
  logic                    slice_ready;
  logic                    slice_valid;
  logic                    slice_last;
  logic [T_DEST_WIDTH-1:0] slice_sel;
  logic [T_DATA_WIDTH-1:0] slice_data;
  logic                    out_ready;

  // Unsigned compare at dest width plus one so M_DATA_COUNT itself fits.
  assign dest_ok   = ({1'b0, s_dest_i} < MCountExt);
  assign s_ready_o = !reset && (state_q == DROP || slice_ready);
  assign fire      = s_valid_i && s_ready_o;

  // Decide whether the accepted beat enters the output register and where it goes.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_sel   = sel_q;
    case (state_q)
      IDLE: begin
        fwd_valid = fire && dest_ok;
        fwd_sel   = s_dest_i;
      end
      PKT: begin
        fwd_valid = fire;
      end
      default: begin
        fwd_valid = 1'b0;
      end
    endcase
  end

  // Only the ready of the output currently holding the beat matters.
  always_comb begin
    out_ready = 1'b0;
    for (int k = 0; k < M_DATA_COUNT; k++) begin
      if (slice_sel == T_DEST_WIDTH'(k)) out_ready = m_ready_i[k];
    end
  end

  // Packet FSM: lock the destination on the first beat, release on last.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire) begin
            if (dest_ok) begin
              sel_q <= s_dest_i;
              if (!s_last_i) state_q <= PKT;
            end else begin
              drop_q <= 1'b1;
              if (!s_last_i) state_q <= DROP;
            end
          end
        end
        PKT: begin
          if (fire && s_last_i) state_q <= IDLE;
        end
        DROP: begin
          if (fire && s_last_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_reg_slice #(
    .DATA_W (T_DATA_WIDTH),
    .SEL_W  (T_DEST_WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .reset       (reset),
    .in_data_i   (s_data_i),
    .in_last_i   (s_last_i),
    .in_sel_i    (fwd_sel),
    .in_valid_i  (fwd_valid),
    .in_ready_o  (slice_ready),
    .out_data_o  (slice_data),
    .out_last_o  (slice_last),
    .out_sel_o   (slice_sel),
    .out_valid_o (slice_valid),
    .out_ready_i (out_ready)
  );

  // Fan the single register out: data/last/id everywhere, valid one-hot.
  always_comb begin
    for (int k = 0; k < M_DATA_COUNT; k++) begin
      m_data_o[k]  = slice_data;
      m_id_o[k]    = ChanId;
      m_last_o[k]  = slice_last;
      m_valid_o[k] = slice_valid && (slice_sel == T_DEST_WIDTH'(k));
    end
  end

  assign drop_o = drop_q;

endmodule

// File: tb/tb_demux_unit.sv
// Scoreboard bench for demux_unit: the driver pushes expected beats when the
// DUT accepts them, and a negedge monitor pops and compares on every handshake.
module tb_demux_unit;

  localparam int M  = 10;
  localparam int DW = 64;
  localparam int CH = 0;

  logic          clk;
  logic          reset;
  logic [DW-1:0] sData;
  logic [3:0]    sDest;
  logic          sLast;
  logic          sValid;
  logic          sReady;
  logic [DW-1:0] mData [M];
  logic [3:0]    mId   [M];
  logic [M-1:0]  mLast;
  logic [M-1:0]  mValid;
  logic [M-1:0]  mReady;
  logic          dropOut;

  demux_unit #(
    .S_DATA_COUNT (10),
    .M_DATA_COUNT (M),
    .T_DATA_WIDTH (DW),
    .NUM_CHANNEL  (CH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data_i  (sData),
    .s_dest_i  (sDest),
    .s_last_i  (sLast),
    .s_valid_i (sValid),
    .s_ready_o (sReady),
    .m_data_o  (mData),
    .m_id_o    (mId),
    .m_last_o  (mLast),
    .m_valid_o (mValid),
    .m_ready_i (mReady),
    .drop_o    (dropOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            port;
  } exp_t;

  exp_t expQ[$];
  int   hsCycles[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  int   dropCount = 0;

  logic          holdPending = 1'b0;
  logic [M-1:0]  holdValid;
  logic [DW-1:0] holdData;
  logic          holdLast;
  int            holdPort;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Drive one beat, wait (bounded) for acceptance, and push the expected
  // output beat; port < 0 means the beat must be discarded.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [3:0] dest,
                               input logic last, input int port);
    int n = 0;
    logic accepted = 1'b0;
    sData  = d;
    sDest  = dest;
    sLast  = last;
    sValid = 1'b1;
    while (!accepted && n < 100) begin
      @(negedge clk);
      if (sReady) accepted = 1'b1;
      n++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: beat 0x%0h not accepted, expected acceptance", d);
    end else if (port >= 0) begin
      expQ.push_back('{data: d, last: last, port: port});
    end
    @(posedge clk);
    #1;
    sValid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue_size", 64'(expQ.size()), 64'd0);
  endtask

  // Drop pulse counter.
  always @(negedge clk) begin
    if (dropOut) dropCount++;
  end

  // Monitor: compare every handshake against the scoreboard and check that a
  // stalled beat is held unchanged into the next cycle.
  always @(negedge clk) begin
    int port;
    exp_t e;
    cycle++;
    if (holdPending) begin
      checkOutput("hold_valid", 64'(mValid), 64'(holdValid));
      checkOutput("hold_data", mData[holdPort], holdData);
      checkOutput("hold_last", 64'(mLast[holdPort]), 64'(holdLast));
      holdPending = 1'b0;
    end
    if (mValid != '0) begin
      checkOutput("valid_onehot", 64'($countones(mValid)), 64'd1);
      port = 0;
      for (int k = M - 1; k >= 0; k--) if (mValid[k]) port = k;
      if (mReady[port]) begin
        hsCycles.push_back(cycle);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: port %0d data 0x%0h, expected no output", port, mData[port]);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_port", 64'(port), 64'(e.port));
          checkOutput("out_data", mData[port], e.data);
          checkOutput("out_last", 64'(mLast[port]), 64'(e.last));
          checkOutput("out_id", 64'(mId[port]), 64'(CH));
        end
      end else if (!reset) begin
        holdPending = 1'b1;
        holdValid   = mValid;
        holdData    = mData[port];
        holdLast    = mLast[port];
        holdPort    = port;
      end
    end
  end

  initial begin
    int startCycle;
    reset  = 1'b1;
    sData  = '0;
    sDest  = '0;
    sLast  = 1'b0;
    sValid = 1'b0;
    mReady = '1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 64'(mValid), 64'd0);
    checkOutput("rst_last", 64'(mLast), 64'd0);
    checkOutput("rst_data0", mData[0], 64'd0);
    checkOutput("rst_drop", 64'(dropOut), 64'd0);
    checkOutput("rst_s_ready", 64'(sReady), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single-beat packet to output 3.
    applyStimulus(64'h11, 4'd3, 1'b1, 3);
    @(negedge clk);
    checkOutput("single_valid_vec", 64'(mValid), 64'h008);
    @(posedge clk);
    #1;
    waitDrain();

    // 4-beat packet locked to output 2 although later beats show dest 7.
    @(posedge clk);
    #1;
    applyStimulus(64'hA0, 4'd2, 1'b0, 2);
    applyStimulus(64'hA1, 4'd7, 1'b0, 2);
    applyStimulus(64'hA2, 4'd7, 1'b0, 2);
    applyStimulus(64'hA3, 4'd7, 1'b1, 2);
    waitDrain();
    checkOutput("lock_back_to_back", 64'(hsCycles[hsCycles.size()-1] - hsCycles[hsCycles.size()-4]), 64'd3);

    // Backpressure on output 5 for 3 cycles mid-packet.
    @(posedge clk);
    #1;
    fork
      begin
        applyStimulus(64'hD0, 4'd5, 1'b0, 5);
        applyStimulus(64'hD1, 4'd5, 1'b0, 5);
        applyStimulus(64'hD2, 4'd5, 1'b0, 5);
        applyStimulus(64'hD3, 4'd5, 1'b1, 5);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        mReady[5] = 1'b0;
        @(negedge clk);
        checkOutput("bp_s_ready_low", 64'(sReady), 64'd0);
        checkOutput("bp_valid5", 64'(mValid[5]), 64'd1);
        repeat (3) @(posedge clk);
        #2;
        mReady[5] = 1'b1;
      end
    join
    waitDrain();

    // Back-to-back packets to outputs 1 then 9 with no bubble.
    @(posedge clk);
    #1;
    hsCycles.delete();
    applyStimulus(64'hB0, 4'd1, 1'b0, 1);
    applyStimulus(64'hB1, 4'd1, 1'b1, 1);
    applyStimulus(64'hC0, 4'd9, 1'b0, 9);
    applyStimulus(64'hC1, 4'd9, 1'b1, 9);
    waitDrain();
    checkOutput("b2b_beats", 64'(hsCycles.size()), 64'd4);
    if (hsCycles.size() == 4)
      checkOutput("b2b_no_bubble", 64'(hsCycles[3] - hsCycles[0]), 64'd3);

    // Invalid dest 12: 3-beat packet consumed at full rate, one drop pulse.
    @(posedge clk);
    #1;
    dropCount  = 0;
    startCycle = cycle;
    applyStimulus(64'hE1, 4'd12, 1'b0, -1);
    applyStimulus(64'hE2, 4'd0,  1'b0, -1);
    applyStimulus(64'hE3, 4'd0,  1'b1, -1);
    checkOutput("drop_rate_cycles", 64'(cycle - startCycle), 64'd3);
    repeat (2) @(negedge clk);
    checkOutput("drop_pulses", 64'(dropCount), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(64'hE0, 4'd0, 1'b1, 0);
    waitDrain();

    // Reset mid-packet with a stalled beat pending on output 4.
    @(posedge clk);
    #1;
    mReady[4] = 1'b0;
    applyStimulus(64'hF0, 4'd4, 1'b0, 4);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_s_ready", 64'(sReady), 64'd0);
    @(negedge clk);
    checkOutput("midrst_valid", 64'(mValid), 64'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mReady = '1;
    applyStimulus(64'hF1, 4'd6, 1'b0, 6);
    applyStimulus(64'hF2, 4'd0, 1'b1, 6);
    waitDrain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
